decode_writeback: RTL and testbench

- Y86-64 pipeline decode/writeback stage; it is the producer side of the D→E pipeline register.
- Holds the 15-entry architectural register file, written from the W stage and read in decode.
- Generates d_srcA, d_srcB, d_dstE, d_dstM, d_valA and d_valB with full data forwarding.
- Flags load-use hazards to the pipeline control logic.

---
 rtl/y86_pkg.sv | 30 +++
 rtl/decode_writeback_if.sv | 38 +++
 rtl/y86_regfile.sv | 57 +++++
 rtl/decode_writeback.sv | 103 ++++++++++
 tb/tb_decode_writeback.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, special register ids and status codes.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_t;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_t;

  localparam logic [3:0] RSP      = 4'h4;
  localparam logic [3:0] RNONE    = 4'hF;
  localparam int         NUM_REGS = 15;

endpackage

// File: rtl/decode_writeback_if.sv
// Decode/writeback pipeline bundle: D-stage fields, forwarding sources and decoded outputs.
interface decode_writeback_if;
  logic [3:0]  D_icode;
  logic [3:0]  D_rA;
  logic [3:0]  D_rB;
  logic [63:0] D_valP;
  logic [3:0]  e_dstE;
  logic [63:0] e_valE;
  logic [3:0]  M_dstE;
  logic [63:0] M_valE;
  logic [3:0]  M_dstM;
  logic [63:0] m_valM;
  logic [3:0]  E_icode;
  logic [3:0]  E_dstM;
  logic [3:0]  W_dstE;
  logic [63:0] W_valE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valM;
  logic [3:0]  d_srcA;
  logic [3:0]  d_srcB;
  logic [3:0]  d_dstE;
  logic [3:0]  d_dstM;
  logic [63:0] d_valA;
  logic [63:0] d_valB;
  logic        load_use;

  modport master (
    output D_icode, D_rA, D_rB, D_valP, e_dstE, e_valE, M_dstE, M_valE,
           M_dstM, m_valM, E_icode, E_dstM, W_dstE, W_valE, W_dstM, W_valM,
    input  d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, load_use
  );

  modport slave (
    input  D_icode, D_rA, D_rB, D_valP, e_dstE, e_valE, M_dstE, M_valE,
           M_dstM, m_valM, E_icode, E_dstM, W_dstE, W_valE, W_dstM, W_valM,
    output d_srcA, d_srcB, d_dstE, d_dstM, d_valA, d_valB, load_use
  );
endinterface

// File: rtl/y86_regfile.sv
// 15x64 architectural register file: async reads (RNONE reads 0), two sync writes, M port wins.
// Optional debug read port enabled by DECODE_WB_DBG_PORT_EN.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter logic [63:0] REG_INIT = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rd_a_addr_i,
  output logic [63:0] rd_a_data_o,
  input  logic [3:0]  rd_b_addr_i,
  output logic [63:0] rd_b_data_o,
`ifdef DECODE_WB_DBG_PORT_EN
  input  logic [3:0]  rd_c_addr_i,
  output logic [63:0] rd_c_data_o,
`endif
  input  logic [3:0]  wr_e_addr_i,
  input  logic [63:0] wr_e_data_i,
  input  logic [3:0]  wr_m_addr_i,
  input  logic [63:0] wr_m_data_i
);

  logic [63:0]         rf_q [NUM_REGS];
  logic [63:0]         rf_d [NUM_REGS];
  logic [NUM_REGS-1:0] we_e;
  logic [NUM_REGS-1:0] we_m;

  // RNONE never matches an index 0..14, so it needs no separate write guard.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
    assign we_e[gi] = (wr_e_addr_i == 4'(gi));
    assign we_m[gi] = (wr_m_addr_i == 4'(gi));
  end

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      rf_d[i] = rf_q[i];
      if (we_e[i]) rf_d[i] = wr_e_data_i;
      if (we_m[i]) rf_d[i] = wr_m_data_i;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) rf_q[i] <= (i == int'(RSP)) ? RSP_INIT : REG_INIT;
      else       rf_q[i] <= rf_d[i];
    end
  end

  assign rd_a_data_o = (rd_a_addr_i == RNONE) ? 64'h0 : rf_q[rd_a_addr_i];
  assign rd_b_data_o = (rd_b_addr_i == RNONE) ? 64'h0 : rf_q[rd_b_addr_i];
`ifdef DECODE_WB_DBG_PORT_EN
  assign rd_c_data_o = (rd_c_addr_i == RNONE) ? 64'h0 : rf_q[rd_c_addr_i];
`endif

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode/writeback stage: register id decode, forwarding, load-use detection.
// Define DECODE_WB_DBG_PORT_EN to add the dbg_sel/dbg_val register peek port.
module decode_writeback
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'h0,
  parameter logic [63:0] REG_INIT = 64'h0
) (
  input  logic               clk,
  input  logic               reset,
  decode_writeback_if.slave  bus
`ifdef DECODE_WB_DBG_PORT_EN
  ,
  input  logic [3:0]         dbg_sel,
  output logic [63:0]        dbg_val
`endif
);

  logic [3:0]  src_a;
  logic [3:0]  src_b;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;
  logic [63:0] rf_a;
  logic [63:0] rf_b;

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.D_icode)
      I_RRMOVQ: begin src_a = bus.D_rA;                   dst_e = bus.D_rB; end
      I_IRMOVQ: begin                                     dst_e = bus.D_rB; end
      I_RMMOVQ: begin src_a = bus.D_rA; src_b = bus.D_rB;                   end
      I_MRMOVQ: begin                   src_b = bus.D_rB; dst_m = bus.D_rA; end
      I_OPQ:    begin src_a = bus.D_rA; src_b = bus.D_rB; dst_e = bus.D_rB; end
      I_CALL:   begin                   src_b = RSP;      dst_e = RSP;      end
      I_RET:    begin src_a = RSP;      src_b = RSP;      dst_e = RSP;      end
      I_PUSHQ:  begin src_a = bus.D_rA; src_b = RSP;      dst_e = RSP;      end
      I_POPQ:   begin src_a = RSP;      src_b = RSP;      dst_e = RSP;
                      dst_m = bus.D_rA;                                     end
      default: ;
    endcase
  end

  y86_regfile #(
    .RSP_INIT (RSP_INIT),
    .REG_INIT (REG_INIT)
  ) u_regfile (
    .clk         (clk),
    .reset       (reset),
    .rd_a_addr_i (src_a),
    .rd_a_data_o (rf_a),
    .rd_b_addr_i (src_b),
    .rd_b_data_o (rf_b),
`ifdef DECODE_WB_DBG_PORT_EN
    .rd_c_addr_i (dbg_sel),
    .rd_c_data_o (dbg_val),
`endif
    .wr_e_addr_i (bus.W_dstE),
    .wr_e_data_i (bus.W_valE),
    .wr_m_addr_i (bus.W_dstM),
    .wr_m_data_i (bus.W_valM)
  );

  // Youngest producer first; the W-stage entries also cover a write landing this very edge.
  function automatic logic [63:0] fwd(
    input logic [3:0]  src,
    input logic [63:0] rf_val,
    input logic [3:0]  e_dst_e, input logic [63:0] e_val_e,
    input logic [3:0]  m_dst_m, input logic [63:0] m_val_m,
    input logic [3:0]  m_dst_e, input logic [63:0] m_val_e,
    input logic [3:0]  w_dst_m, input logic [63:0] w_val_m,
    input logic [3:0]  w_dst_e, input logic [63:0] w_val_e
  );
    if (src == RNONE)        return 64'h0;
    else if (src == e_dst_e) return e_val_e;
    else if (src == m_dst_m) return m_val_m;
    else if (src == m_dst_e) return m_val_e;
    else if (src == w_dst_m) return w_val_m;
    else if (src == w_dst_e) return w_val_e;
    else                     return rf_val;
  endfunction

  assign bus.d_srcA = src_a;
  assign bus.d_srcB = src_b;
  assign bus.d_dstE = dst_e;
  assign bus.d_dstM = dst_m;

  assign bus.d_valA = (bus.D_icode == I_JXX || bus.D_icode == I_CALL) ? bus.D_valP :
                      fwd(src_a, rf_a, bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                          bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM,
                          bus.W_dstE, bus.W_valE);

  assign bus.d_valB = fwd(src_b, rf_b, bus.e_dstE, bus.e_valE, bus.M_dstM, bus.m_valM,
                          bus.M_dstE, bus.M_valE, bus.W_dstM, bus.W_valM,
                          bus.W_dstE, bus.W_valE);

  assign bus.load_use = (bus.E_icode == I_MRMOVQ || bus.E_icode == I_POPQ) &&
                        (bus.E_dstM != RNONE) &&
                        (bus.E_dstM == src_a || bus.E_dstM == src_b);

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: stimulus queues expectations, negedge monitor checks them.
module tb_decode_writeback;
  import y86_pkg::*;

  localparam logic [63:0] RSP_INIT_TB = 64'h200;

  localparam int F_VALA = 0;
  localparam int F_VALB = 1;
  localparam int F_SRCA = 2;
  localparam int F_SRCB = 3;
  localparam int F_DSTE = 4;
  localparam int F_DSTM = 5;
  localparam int F_LU   = 6;

  typedef struct {
    string       name;
    int          field;
    logic [63:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic obs_valid = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  decode_writeback_if dw_if ();

`ifdef DECODE_WB_DBG_PORT_EN
  logic [63:0] dbg_val_w;
`endif

  decode_writeback #(
    .RSP_INIT (RSP_INIT_TB),
    .REG_INIT (64'h0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (dw_if)
`ifdef DECODE_WB_DBG_PORT_EN
    ,
    .dbg_sel (4'hF),
    .dbg_val (dbg_val_w)
`endif
  );

  function automatic logic [63:0] observe(input int f);
    case (f)
      F_VALA:  return dw_if.d_valA;
      F_VALB:  return dw_if.d_valB;
      F_SRCA:  return {60'h0, dw_if.d_srcA};
      F_SRCB:  return {60'h0, dw_if.d_srcB};
      F_DSTE:  return {60'h0, dw_if.d_dstE};
      F_DSTM:  return {60'h0, dw_if.d_dstM};
      default: return {63'h0, dw_if.load_use};
    endcase
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [63:0] act;
    if (obs_valid) begin
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = observe(e.field);
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end else begin
          $display("ok   %s: %h", e.name, act);
        end
      end
    end
  end

  task automatic want(input string name, input int f, input logic [63:0] v);
    exp_t e;
    e.name  = name;
    e.field = f;
    e.exp   = v;
    exp_q.push_back(e);
  endtask

  task automatic cycle();
    obs_valid = 1'b1;
    @(posedge clk);
    #1;
    obs_valid = 1'b0;
  endtask

  task automatic idle();
    dw_if.D_icode = 4'h1;  dw_if.D_rA = RNONE;   dw_if.D_rB = RNONE;  dw_if.D_valP = 64'h0;
    dw_if.e_dstE  = RNONE; dw_if.e_valE = 64'h0;
    dw_if.M_dstE  = RNONE; dw_if.M_valE = 64'h0;
    dw_if.M_dstM  = RNONE; dw_if.m_valM = 64'h0;
    dw_if.E_icode = 4'h1;  dw_if.E_dstM = RNONE;
    dw_if.W_dstE  = RNONE; dw_if.W_valE = 64'h0;
    dw_if.W_dstM  = RNONE; dw_if.W_valM = 64'h0;
  endtask

  task automatic decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    dw_if.D_icode = ic;
    dw_if.D_rA    = ra;
    dw_if.D_rB    = rb;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin : stimulus
    reset = 1'b1;
    idle();
    @(posedge clk);
    #1;
    // outputs are combinational even while reset is held
    decode(4'h6, 4'h1, RNONE);
    want("srcA_during_reset", F_SRCA, 64'h1);
    cycle();
    reset = 1'b0;
    idle();

    // reset contents of every register
    for (int r = 0; r < 15; r++) begin
      decode(4'h6, 4'(r), RNONE);
      want($sformatf("reset_rf%0d", r), F_VALA, (r == 4) ? RSP_INIT_TB : 64'h0);
      if (r == 0) want("rnone_read_valB", F_VALB, 64'h0);
      cycle();
    end

    decode(4'h5, 4'h3, 4'h4);
    want("mrmovq_srcB", F_SRCB, 64'h4);
    want("mrmovq_valB_rsp", F_VALB, 64'h200);
    want("mrmovq_dstE", F_DSTE, 64'hF);
    want("mrmovq_dstM", F_DSTM, 64'h3);
    cycle();

    // W write to r3, forwarded in the write cycle and read from the file afterwards
    decode(4'h6, 4'h3, RNONE);
    dw_if.W_dstE = 4'h3; dw_if.W_valE = 64'h55;
    want("w_fwd_r3", F_VALA, 64'h55);
    cycle();
    dw_if.W_dstE = RNONE;
    want("rf_r3_written", F_VALA, 64'h55);
    cycle();

    // forwarding priority on r2
    decode(4'h6, 4'h2, RNONE);
    dw_if.e_dstE = 4'h2; dw_if.e_valE = 64'h1;
    dw_if.M_dstM = 4'h2; dw_if.m_valM = 64'h2;
    dw_if.W_dstE = 4'h2; dw_if.W_valE = 64'h3;
    want("prio_e", F_VALA, 64'h1);
    cycle();
    dw_if.e_dstE = RNONE;
    want("prio_mM", F_VALA, 64'h2);
    cycle();
    dw_if.M_dstM = RNONE;
    want("prio_wE", F_VALA, 64'h3);
    cycle();
    dw_if.W_dstE = RNONE;
    dw_if.M_dstE = 4'h2; dw_if.M_valE = 64'h7;
    want("prio_mE", F_VALA, 64'h7);
    cycle();
    dw_if.M_dstE = RNONE;
    dw_if.W_dstM = 4'h2; dw_if.W_valM = 64'hA;
    dw_if.W_dstE = 4'h2; dw_if.W_valE = 64'hB;
    want("prio_wM_over_wE", F_VALA, 64'hA);
    cycle();
    dw_if.W_dstM = RNONE; dw_if.W_dstE = RNONE;
    decode(4'h6, RNONE, 4'h2);
    want("rf_r2_valB", F_VALB, 64'hA);
    want("rnone_srcA_valA", F_VALA, 64'h0);
    cycle();
    decode(4'h6, 4'h5, 4'h5);
    dw_if.M_dstM = 4'h5; dw_if.m_valM = 64'h11;
    dw_if.M_dstE = 4'h5; dw_if.M_valE = 64'h22;
    want("prio_mM_over_mE_A", F_VALA, 64'h11);
    want("prio_mM_over_mE_B", F_VALB, 64'h11);
    cycle();
    dw_if.M_dstM = RNONE; dw_if.M_dstE = RNONE;

    // simultaneous W writes to rsp: valM wins
    decode(4'h6, 4'h4, RNONE);
    dw_if.W_dstE = 4'h4; dw_if.W_valE = 64'h8;
    dw_if.W_dstM = 4'h4; dw_if.W_valM = 64'h9;
    want("w_both_fwd", F_VALA, 64'h9);
    cycle();
    dw_if.W_dstE = RNONE; dw_if.W_dstM = RNONE;
    want("rf_r4_valM_wins", F_VALA, 64'h9);
    cycle();

    // reset overrides a simultaneous write
    reset = 1'b1;
    dw_if.W_dstE = 4'h4; dw_if.W_valE = 64'h77;
    dw_if.W_dstM = 4'h4; dw_if.W_valM = 64'h78;
    want("fwd_during_reset", F_VALA, 64'h78);
    cycle();
    reset = 1'b0;
    dw_if.W_dstE = RNONE; dw_if.W_dstM = RNONE;
    want("rf_r4_reset_wins", F_VALA, RSP_INIT_TB);
    cycle();
    decode(4'h6, 4'h2, 4'h3);
    want("rf_r2_cleared", F_VALA, 64'h0);
    want("rf_r3_cleared", F_VALB, 64'h0);
    cycle();

    // load/use hazard
    decode(4'h6, 4'h6, RNONE);
    dw_if.E_icode = 4'h5; dw_if.E_dstM = 4'h6;
    want("lu_mrmovq_srcA", F_LU, 64'h1);
    cycle();
    dw_if.E_icode = 4'h3;
    want("lu_irmovq", F_LU, 64'h0);
    cycle();
    dw_if.E_icode = 4'hB;
    decode(4'h6, 4'h1, 4'h6);
    want("lu_popq_srcB", F_LU, 64'h1);
    cycle();
    dw_if.E_icode = 4'h5; dw_if.E_dstM = RNONE;
    decode(4'h2, RNONE, RNONE);
    want("lu_rnone", F_LU, 64'h0);
    cycle();
    dw_if.E_icode = 4'h1;

    // call / jxx use valP
    decode(4'h8, RNONE, RNONE);
    dw_if.D_valP = 64'h1234;
    dw_if.e_dstE = 4'h4; dw_if.e_valE = 64'h99;
    want("call_valA", F_VALA, 64'h1234);
    want("call_srcA", F_SRCA, 64'hF);
    want("call_srcB", F_SRCB, 64'h4);
    want("call_dstE", F_DSTE, 64'h4);
    want("call_dstM", F_DSTM, 64'hF);
    want("call_valB_fwd", F_VALB, 64'h99);
    cycle();
    dw_if.e_dstE = RNONE;
    decode(4'h7, RNONE, RNONE);
    dw_if.D_valP = 64'h5678;
    want("jxx_valA", F_VALA, 64'h5678);
    want("jxx_srcB", F_SRCB, 64'hF);
    cycle();

    // out-of-range icode, with a live RNONE forward that must not fire
    decode(4'hC, 4'h1, 4'h2);
    dw_if.e_dstE = RNONE; dw_if.e_valE = 64'hDEAD;
    want("bad_srcA", F_SRCA, 64'hF);
    want("bad_srcB", F_SRCB, 64'hF);
    want("bad_dstE", F_DSTE, 64'hF);
    want("bad_dstM", F_DSTM, 64'hF);
    want("bad_valA", F_VALA, 64'h0);
    want("bad_valB", F_VALB, 64'h0);
    cycle();
    dw_if.e_valE = 64'h0;

    // remaining id decode
    decode(4'h9, RNONE, RNONE);
    want("ret_srcA", F_SRCA, 64'h4);
    want("ret_dstE", F_DSTE, 64'h4);
    cycle();
    decode(4'hB, 4'h3, RNONE);
    want("popq_srcA", F_SRCA, 64'h4);
    want("popq_srcB", F_SRCB, 64'h4);
    want("popq_dstM", F_DSTM, 64'h3);
    cycle();
    decode(4'hA, 4'h5, RNONE);
    want("pushq_srcA", F_SRCA, 64'h5);
    want("pushq_dstE", F_DSTE, 64'h4);
    want("pushq_dstM", F_DSTM, 64'hF);
    cycle();
    decode(4'h2, 4'h1, 4'h2);
    want("rrmovq_srcA", F_SRCA, 64'h1);
    want("rrmovq_srcB", F_SRCB, 64'hF);
    want("rrmovq_dstE", F_DSTE, 64'h2);
    cycle();
    decode(4'h3, RNONE, 4'h7);
    want("irmovq_srcB", F_SRCB, 64'hF);
    want("irmovq_dstE", F_DSTE, 64'h7);
    cycle();
    decode(4'h4, 4'h1, 4'h2);
    want("rmmovq_srcB", F_SRCB, 64'h2);
    want("rmmovq_dstE", F_DSTE, 64'hF);
    cycle();
    decode(4'h0, 4'h1, 4'h2);
    want("halt_srcA", F_SRCA, 64'hF);
    want("halt_dstE", F_DSTE, 64'hF);
    cycle();

    idle();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
